// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS control slice.
// Holds the controller state enum, opcode/funct values, the e_op/alu_op/pc_src
// encodings shared with the extender, ALU and PC mux, the control-word struct,
// and a classifier that maps (opcode, funct) to an instruction kind.
// No ports (package).
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, WBM, BRANCH, JUMP, TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_OR    = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  localparam logic [1:0] E_SIGN  = 2'd0;
  localparam logic [1:0] E_ZERO  = 2'd1;
  localparam logic [1:0] E_UPPER = 2'd2;
  localparam logic [1:0] E_SHL2  = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_ILL
  } instr_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       wd_sel;
    logic [1:0] alu_op;
    logic       alu_b_sel;
    logic [1:0] e_op;
  } ctrl_t;

  // Anything outside the supported subset comes back as I_ILL; the caller
  // decides whether that traps or behaves like a nop.
  function automatic instr_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_e kind;
    kind = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_NOP:  kind = I_NOP;
          FN_ADDU: kind = I_ADDU;
          FN_SUBU: kind = I_SUBU;
          default: kind = I_ILL;
        endcase
      end
      OP_ORI:  kind = I_ORI;
      OP_LUI:  kind = I_LUI;
      OP_LW:   kind = I_LW;
      OP_SW:   kind = I_SW;
      OP_BEQ:  kind = I_BEQ;
      OP_J:    kind = I_J;
      default: kind = I_ILL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the control FSM and the datapath.
// master modport (controller side):
//   in  opcode[5:0], funct[5:0], alu_zero, mem_ready
//   out mem_req, mem_we, ir_we, pc_we, pc_src[1:0], reg_we, reg_dst, wd_sel,
//       alu_op[1:0], alu_b_sel, e_op[1:0], instr_cnt[CNT_W-1:0], illegal
// slave modport (datapath side): same signals, opposite directions.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             reg_we;
  logic             reg_dst;
  logic             wd_sel;
  logic [1:0]       alu_op;
  logic             alu_b_sel;
  logic [1:0]       e_op;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel,
           alu_op, alu_b_sel, e_op, instr_cnt, illegal
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel,
           alu_op, alu_b_sel, e_op, instr_cnt, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational map from controller state plus latched op/funct
// to the datapath control word.
// Ports:
//   state_i      current FSM state
//   op_i         latched opcode
//   funct_i      latched funct
//   alu_zero_i   ALU zero flag (qualifies the branch PC write)
//   mem_ready_i  memory done (qualifies IR/PC load in FETCH)
//   ctrl_o       control word
module mc_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       alu_zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  instr_e instr;
  assign instr = classify(op_i, funct_i);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.ir_we   = mem_ready_i;
        ctrl_o.pc_we   = mem_ready_i;
        ctrl_o.pc_src  = PC_SEQ;
      end
      // WB keeps the EXEC ALU/extender settings so the result stays stable
      // while the register file captures it.
      EXEC, WB: begin
        case (instr)
          I_ADDU: begin ctrl_o.alu_op = ALU_ADD;   ctrl_o.alu_b_sel = 1'b0; end
          I_SUBU: begin ctrl_o.alu_op = ALU_SUB;   ctrl_o.alu_b_sel = 1'b0; end
          I_ORI:  begin ctrl_o.alu_op = ALU_OR;    ctrl_o.alu_b_sel = 1'b1; ctrl_o.e_op = E_ZERO;  end
          I_LUI:  begin ctrl_o.alu_op = ALU_PASSB; ctrl_o.alu_b_sel = 1'b1; ctrl_o.e_op = E_UPPER; end
          I_LW, I_SW: begin ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_b_sel = 1'b1; ctrl_o.e_op = E_SIGN; end
          default: ;
        endcase
        if (state_i == WB) begin
          ctrl_o.reg_we  = 1'b1;
          ctrl_o.wd_sel  = 1'b0;
          ctrl_o.reg_dst = (instr == I_ADDU) || (instr == I_SUBU);
        end
      end
      MEM: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = (instr == I_SW);
      end
      WBM: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.wd_sel = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.e_op   = E_SHL2;
        ctrl_o.pc_src = PC_BRANCH;
        ctrl_o.pc_we  = alu_zero_i;
      end
      JUMP: begin
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.pc_src = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the single-memory MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB for addu, subu, ori, lw, sw, beq, lui,
// j and nop, and counts retired instructions.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mc_ctrl_if.master (opcode/funct/alu_zero/mem_ready in,
//          control strobes, instr_cnt and illegal out)
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to send unknown
// instructions to a TRAP state with a sticky illegal flag; otherwise they
// retire as nops and illegal is tied 0.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  instr_e           instr_q;
  ctrl_t            ctrl;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  assign instr_q = classify(op_q, funct_q);

  // Next state. DECODE routes on the live opcode/funct while capturing them;
  // every later state works from the captured copy.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        op_d    = bus.opcode;
        funct_d = bus.funct;
        case (classify(bus.opcode, bus.funct))
          I_NOP: state_d = FETCH;
          I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW: state_d = EXEC;
          I_BEQ: state_d = BRANCH;
          I_J:   state_d = JUMP;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d   = TRAP;
            illegal_d = 1'b1;
`else
            state_d   = FETCH;
`endif
          end
        endcase
      end
      EXEC:  state_d = ((instr_q == I_LW) || (instr_q == I_SW)) ? MEM : WB;
      MEM:   if (bus.mem_ready) state_d = (instr_q == I_LW) ? WBM : FETCH;
      WB, WBM, BRANCH, JUMP: state_d = FETCH;
      TRAP:  state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // An instruction retires on any return to FETCH except the initial one.
  always_comb begin
    retire = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);
    cnt_d  = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  // State, captured instruction fields and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  mc_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .funct_i     (funct_q),
    .alu_zero_i  (bus.alu_zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.mem_req   = ctrl.mem_req;
  assign bus.mem_we    = ctrl.mem_we;
  assign bus.ir_we     = ctrl.ir_we;
  assign bus.pc_we     = ctrl.pc_we;
  assign bus.pc_src    = ctrl.pc_src;
  assign bus.reg_we    = ctrl.reg_we;
  assign bus.reg_dst   = ctrl.reg_dst;
  assign bus.wd_sel    = ctrl.wd_sel;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.alu_b_sel = ctrl.alu_b_sel;
  assign bus.e_op      = ctrl.e_op;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Walks each instruction
// cycle by cycle against an instruction-level table of expected control
// words, with random stalls, random don't-care inputs and a random stream.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_mc_ctrl;

  localparam int KNOP = 0, KADDU = 1, KSUBU = 2, KORI = 3, KLUI = 4,
                 KLW = 5, KSW = 6, KBEQ = 7, KJ = 8, KILL = 9;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;
  int   cntExp;

  logic [5:0] opTab [10];
  logic [5:0] fnTab [3];

  mc_ctrl_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  // Control word packing: mem_req, mem_we, ir_we, pc_we, pc_src, reg_we,
  // reg_dst, wd_sel, alu_op, alu_b_sel, e_op.
  function automatic logic [13:0] mk(input logic mreq, input logic mwe,
                                     input logic irwe, input logic pcwe,
                                     input logic [1:0] pcsrc, input logic rwe,
                                     input logic rdst, input logic wds,
                                     input logic [1:0] aop, input logic bsel,
                                     input logic [1:0] eop);
    return {mreq, mwe, irwe, pcwe, pcsrc, rwe, rdst, wds, aop, bsel, eop};
  endfunction

  // ALU/extender settings for the execute step of each instruction kind.
  function automatic logic [13:0] execVec(input int kind);
    case (kind)
      KADDU:    return mk(0,0,0,0,2'd0,0,0,0,2'd0,0,2'd0);
      KSUBU:    return mk(0,0,0,0,2'd0,0,0,0,2'd1,0,2'd0);
      KORI:     return mk(0,0,0,0,2'd0,0,0,0,2'd2,1,2'd1);
      KLUI:     return mk(0,0,0,0,2'd0,0,0,0,2'd3,1,2'd2);
      default:  return mk(0,0,0,0,2'd0,0,0,0,2'd0,1,2'd0);
    endcase
  endfunction

  task automatic applyStimulus(input logic mr, input logic az,
                               input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    bus.mem_ready = mr;
    bus.alu_zero  = az;
    bus.opcode    = op;
    bus.funct     = fn;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] expVec);
    logic [13:0] obs;
    obs = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we,
           bus.reg_dst, bus.wd_sel, bus.alu_op, bus.alu_b_sel, bus.e_op};
    vecCount++;
    assert (obs === expVec) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expVec);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] expCnt);
    vecCount++;
    assert (bus.instr_cnt === expCnt) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, bus.instr_cnt, expCnt);
    end
  endtask

  task automatic checkIllegal(input string tag, input logic expIll);
    vecCount++;
    assert (bus.illegal === expIll) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, bus.illegal, expIll);
    end
  endtask

  task automatic step(input logic mr, input logic az, input logic [5:0] op,
                      input logic [5:0] fn, input string tag, input logic [13:0] expVec);
    applyStimulus(mr, az, op, fn);
    checkOutput(tag, expVec);
  endtask

  // Runs one whole instruction starting in FETCH; opcode/funct are only
  // meaningful in the decode cycle and are scrambled everywhere else.
  task automatic runInstr(input int kind, input int fStall, input int mStall, input logic zero);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [13:0] ev;
    op = opTab[kind];
    fn = (kind <= KSUBU) ? fnTab[kind] : r6();
    for (int i = 0; i < fStall; i++)
      step(1'b0, rb(), r6(), r6(), "fetchWait", mk(1,0,0,0,2'd0,0,0,0,2'd0,0,2'd0));
    step(1'b1, rb(), r6(), r6(), "fetch", mk(1,0,1,1,2'd0,0,0,0,2'd0,0,2'd0));
    step(rb(), rb(), op, fn, "decode", '0);
    case (kind)
      KADDU, KSUBU, KORI, KLUI: begin
        ev = execVec(kind);
        step(rb(), rb(), r6(), r6(), "exec", ev);
        step(rb(), rb(), r6(), r6(), "wb",
             ev | mk(0,0,0,0,2'd0,1,(kind <= KSUBU),0,2'd0,0,2'd0));
      end
      KLW, KSW: begin
        step(rb(), rb(), r6(), r6(), "execMem", execVec(kind));
        for (int i = 0; i < mStall; i++)
          step(1'b0, rb(), r6(), r6(), "memWait", mk(1,(kind == KSW),0,0,2'd0,0,0,0,2'd0,0,2'd0));
        step(1'b1, rb(), r6(), r6(), "mem", mk(1,(kind == KSW),0,0,2'd0,0,0,0,2'd0,0,2'd0));
        if (kind == KLW)
          step(rb(), rb(), r6(), r6(), "wbm", mk(0,0,0,0,2'd0,1,0,1,2'd0,0,2'd0));
      end
      KBEQ: step(rb(), zero, r6(), r6(), "branch", mk(0,0,0,zero,2'd1,0,0,0,2'd1,0,2'd3));
      KJ:   step(rb(), rb(), r6(), r6(), "jump", mk(0,0,0,1,2'd2,0,0,0,2'd0,0,2'd0));
      default: ;
    endcase
    cntExp++;
    @(posedge clk);
    #1;
    checkCount("instrCnt", cntExp);
  endtask

  // Directed walk through the instruction set, a random stream, reset in
  // the middle of a store, then the illegal-opcode behaviour.
  initial begin
    vecCount  = 0;
    missCount = 0;
    cntExp    = 0;
    opTab = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
              6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111};
    fnTab = '{6'b000000, 6'b100001, 6'b100011};
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetOut", '0);
    checkCount("resetCnt", 0);
    checkIllegal("resetIll", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle", '0);

    runInstr(KADDU, 0, 0, 1'b0);
    runInstr(KLW, 0, 3, 1'b0);
    runInstr(KBEQ, 0, 0, 1'b1);
    runInstr(KBEQ, 0, 0, 1'b0);
    runInstr(KORI, 0, 0, 1'b0);
    runInstr(KLUI, 0, 0, 1'b0);
    runInstr(KJ, 0, 0, 1'b0);
    runInstr(KSW, 2, 1, 1'b0);
    runInstr(KSUBU, 1, 0, 1'b0);
    runInstr(KNOP, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++)
      runInstr(int'($urandom_range(8, 0)), int'($urandom_range(2, 0)),
               int'($urandom_range(2, 0)), rb());

    step(1'b1, rb(), r6(), r6(), "fetchSw", mk(1,0,1,1,2'd0,0,0,0,2'd0,0,2'd0));
    step(rb(), rb(), opTab[KSW], r6(), "decodeSw", '0);
    step(rb(), rb(), r6(), r6(), "execSw", execVec(KSW));
    step(1'b0, rb(), r6(), r6(), "memSw", mk(1,1,0,0,2'd0,0,0,0,2'd0,0,2'd0));
    rst_n = 1'b0;
    #1;
    checkOutput("rstDrop", '0);
    checkCount("rstCnt", 0);
    cntExp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle2", '0);
    runInstr(KNOP, 0, 0, 1'b0);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step(1'b1, rb(), r6(), r6(), "fetchIll", mk(1,0,1,1,2'd0,0,0,0,2'd0,0,2'd0));
    step(rb(), rb(), opTab[KILL], r6(), "decodeIll", '0);
    for (int i = 0; i < 3; i++)
      step(rb(), rb(), r6(), r6(), "trap", '0);
    checkCount("trapCnt", cntExp);
    checkIllegal("trapIll", 1'b1);
`else
    runInstr(KILL, 0, 0, 1'b0);
    checkIllegal("illTied", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
